fpu_seq: RTL and testbench

//  Issue/sequencing stage directly upstream of the combinational FPU (fadd/fsub/fmul/fdiv/feq/flt/fle).

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_lat_sel.sv | 32 +++
 rtl/fpu_seq.sv | 132 +++++++++++++
 tb/tb_fpu_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and defaults for the FPU issue/sequencing stage.
package fpu_pkg;

   localparam int OP_FADD = 0;
   localparam int OP_FSUB = 1;
   localparam int OP_FMUL = 2;
   localparam int OP_FDIV = 3;
   localparam int OP_FEQ  = 4;
   localparam int OP_FLT  = 5;
   localparam int OP_FLE  = 6;

   typedef logic [6:0] fpu_op_t;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} fpu_state_t;

   localparam int DEF_ADD_LAT = 2;
   localparam int DEF_MUL_LAT = 3;
   localparam int DEF_DIV_LAT = 8;
   localparam int DEF_CMP_LAT = 1;

   function automatic logic op_is_onehot(fpu_op_t op);
      return (op != '0) && ((op & (op - 7'd1)) == '0);
   endfunction

   function automatic int max_lat(int a, int b, int c, int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/fpu_lat_sel.sv
// One-hot FPU op to (latency - 1); anything not exactly one-hot maps to 0.
module fpu_lat_sel
   import fpu_pkg::*;
#(
   parameter int ADD_LAT = DEF_ADD_LAT,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT,
   parameter int CMP_LAT = DEF_CMP_LAT,
   parameter int CNT_W   = 4
) (
   input  logic [6:0]       i_op,
   output logic [CNT_W-1:0] o_lat_m1
);

   logic w_onehot;
   assign w_onehot = op_is_onehot(i_op);

   always_comb begin
      o_lat_m1 = '0;
      if (w_onehot) begin
         if (i_op[OP_FADD] | i_op[OP_FSUB])
            o_lat_m1 = CNT_W'(ADD_LAT - 1);
         else if (i_op[OP_FMUL])
            o_lat_m1 = CNT_W'(MUL_LAT - 1);
         else if (i_op[OP_FDIV])
            o_lat_m1 = CNT_W'(DIV_LAT - 1);
         else
            o_lat_m1 = CNT_W'(CMP_LAT - 1);
      end
   end

endmodule

// File: rtl/fpu_seq.sv
// Issue/sequencing stage in front of the combinational FPU: holds operands for the
// op's latency, captures the result, and hands it to writeback with its tag.
module fpu_seq
   import fpu_pkg::*;
#(
   parameter int TAG_W   = 5,
   parameter int ADD_LAT = DEF_ADD_LAT,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DIV_LAT = DEF_DIV_LAT,
   parameter int CMP_LAT = DEF_CMP_LAT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [6:0]       i_in_op,
   input  logic [31:0]      i_in_src1,
   input  logic [31:0]      i_in_src2,
   input  logic [TAG_W-1:0] i_in_tag,
   output logic [6:0]       o_fpu_op,
   output logic [31:0]      o_fpu_src1,
   output logic [31:0]      o_fpu_src2,
   input  logic [31:0]      i_fpu_result,
   input  logic             i_fpu_ovf,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [31:0]      o_out_data,
   output logic             o_out_ovf,
   output logic             o_out_illegal,
   output logic [TAG_W-1:0] o_out_tag
);

   localparam int MAX_LAT = max_lat(ADD_LAT, MUL_LAT, DIV_LAT, CMP_LAT);
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

   fpu_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [6:0]       r_fpu_op;
   logic [31:0]      r_fpu_src1;
   logic [31:0]      r_fpu_src2;
   logic [TAG_W-1:0] r_tag;
   logic             r_illegal;
   logic             r_cmp;
   logic [31:0]      r_out_data;
   logic             r_out_ovf;
   logic             r_out_illegal;
   logic [TAG_W-1:0] r_out_tag;

   logic [CNT_W-1:0] w_lat_m1;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_in_onehot;

   fpu_lat_sel #(
      .ADD_LAT (ADD_LAT),
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT),
      .CMP_LAT (CMP_LAT),
      .CNT_W   (CNT_W)
   ) u_lat_sel (
      .i_op     (i_in_op),
      .o_lat_m1 (w_lat_m1)
   );

   assign w_in_onehot = op_is_onehot(i_in_op);
   assign w_in_ready  = (r_state == IDLE) | ((r_state == DONE) & i_out_ready);
   assign w_accept    = i_in_valid & w_in_ready & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_fpu_op      <= '0;
         r_fpu_src1    <= '0;
         r_fpu_src2    <= '0;
         r_tag         <= '0;
         r_illegal     <= 1'b0;
         r_cmp         <= 1'b0;
         r_out_data    <= '0;
         r_out_ovf     <= 1'b0;
         r_out_illegal <= 1'b0;
         r_out_tag     <= '0;
      end else if (i_flush) begin
         r_state  <= IDLE;
         r_fpu_op <= '0;
      end else if (w_accept) begin
         // Accept covers both IDLE and the back-to-back DONE handoff.
         r_state    <= EXEC;
         r_cnt      <= w_lat_m1;
         r_fpu_op   <= w_in_onehot ? i_in_op : 7'd0;
         r_fpu_src1 <= i_in_src1;
         r_fpu_src2 <= i_in_src2;
         r_tag      <= i_in_tag;
         r_illegal  <= ~w_in_onehot;
         r_cmp      <= |i_in_op[OP_FLE:OP_FEQ];
      end else begin
         case (r_state)
            EXEC: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state       <= DONE;
                  r_out_data    <= r_illegal ? 32'd0 :
                                   r_cmp     ? {31'd0, i_fpu_result[0]} : i_fpu_result;
                  r_out_ovf     <= ~r_illegal & ~r_cmp & i_fpu_ovf;
                  r_out_illegal <= r_illegal;
                  r_out_tag     <= r_tag;
               end
            end
            DONE: begin
               if (i_out_ready) begin
                  r_state  <= IDLE;
                  r_fpu_op <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready    = w_in_ready;
   assign o_out_valid   = (r_state == DONE);
   assign o_fpu_op      = r_fpu_op;
   assign o_fpu_src1    = r_fpu_src1;
   assign o_fpu_src2    = r_fpu_src2;
   assign o_out_data    = r_out_data;
   assign o_out_ovf     = r_out_ovf;
   assign o_out_illegal = r_out_illegal;
   assign o_out_tag     = r_out_tag;

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq: mock FPU, transaction-level timing model, directed + random stimulus.
module tb_fpu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_op = '0;
   logic [31:0] in_src1 = '0;
   logic [31:0] in_src2 = '0;
   logic [4:0]  in_tag = '0;
   logic [6:0]  fpu_op;
   logic [31:0] fpu_src1, fpu_src2, fpu_result;
   logic        fpu_ovf;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_ovf, out_illegal;
   logic [4:0]  out_tag;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   fpu_seq #(.TAG_W(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op),
      .i_in_src1(in_src1), .i_in_src2(in_src2), .i_in_tag(in_tag),
      .o_fpu_op(fpu_op), .o_fpu_src1(fpu_src1), .o_fpu_src2(fpu_src2),
      .i_fpu_result(fpu_result), .i_fpu_ovf(fpu_ovf),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_out_ovf(out_ovf), .o_out_illegal(out_illegal), .o_out_tag(out_tag)
   );

   // ---------------- float helpers and mock FPU ----------------
   function automatic real s2d(logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) d = {f[31], 63'd0};
      else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [32:0] d2s(real r);
      logic [63:0] b;
      int se;
      b = $realtobits(r);
      se = int'(b[62:52]) - 1023 + 127;
      if (b[62:0] == 63'd0 || se <= 0) return {1'b0, b[63], 31'd0};
      if (se >= 255) return {1'b1, b[63], 8'hFF, 23'd0};
      return {1'b0, b[63], se[7:0], b[51:29]};
   endfunction

   // returns {ovf, result}; compares put junk in upper bits and ovf=1 so masking is exercised
   function automatic logic [32:0] fpu_mock(logic [6:0] op, logic [31:0] a, logic [31:0] b);
      real x, y;
      x = s2d(a);
      y = s2d(b);
      case (op)
         7'b0000001: return d2s(x + y);
         7'b0000010: return d2s(x - y);
         7'b0000100: return d2s(x * y);
         7'b0001000: return d2s(x / y);
         7'b0010000: return {1'b1, a[31:1] ^ b[31:1], x == y};
         7'b0100000: return {1'b1, a[31:1] ^ b[31:1], x < y};
         7'b1000000: return {1'b1, a[31:1] ^ b[31:1], x <= y};
         default:    return {1'b1, 32'hDEADBEEF};
      endcase
   endfunction

   always_comb {fpu_ovf, fpu_result} = fpu_mock(fpu_op, fpu_src1, fpu_src2);

   function automatic int lat_of(logic [6:0] op);
      case (op)
         7'b0000001, 7'b0000010: return 2;
         7'b0000100:             return 3;
         7'b0001000:             return 8;
         default:                return 1;
      endcase
   endfunction

   function automatic logic legal(logic [6:0] op);
      return $countones(op) == 1;
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          m_has = 1'b0;
   logic [6:0]  m_op;
   logic [31:0] m_a, m_b;
   logic [4:0]  m_tag;
   int          m_acc = 0, m_lat = 0, cyc = 0;

   function automatic logic exp_valid();
      return m_has && (cyc >= m_acc + m_lat);
   endfunction

   function automatic logic exp_ready();
      return !m_has || (exp_valid() && out_ready);
   endfunction

   always @(posedge clk) begin
      if (rst || flush) m_has <= 1'b0;
      else begin
         if (exp_valid() && out_ready) m_has <= 1'b0;
         if (in_valid && exp_ready()) begin
            m_has <= 1'b1;
            m_op  <= in_op;
            m_a   <= in_src1;
            m_b   <= in_src2;
            m_tag <= in_tag;
            m_acc <= cyc + 1;
            m_lat <= lat_of(in_op);
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      logic [32:0] r;
      logic [31:0] ed;
      logic        eo;
      check("out_valid", 64'(out_valid), 64'(exp_valid()));
      check("in_ready", 64'(in_ready), 64'(exp_ready()));
      if (m_has) begin
         check("fpu_op", 64'(fpu_op), 64'(legal(m_op) ? m_op : 7'd0));
         check("fpu_src1", 64'(fpu_src1), 64'(m_a));
         check("fpu_src2", 64'(fpu_src2), 64'(m_b));
      end else begin
         check("fpu_op_idle", 64'(fpu_op), 64'd0);
      end
      if (exp_valid()) begin
         r = fpu_mock(m_op, m_a, m_b);
         if (!legal(m_op)) begin ed = 32'd0; eo = 1'b0; end
         else if (m_op[6:4] != 3'd0) begin ed = {31'd0, r[0]}; eo = 1'b0; end
         else begin ed = r[31:0]; eo = r[32]; end
         check("out_data", 64'(out_data), 64'(ed));
         check("out_ovf", 64'(out_ovf), 64'(eo));
         check("out_illegal", 64'(out_illegal), 64'(!legal(m_op)));
         check("out_tag", 64'(out_tag), 64'(m_tag));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic issue(logic [6:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
      bit acc;
      acc = 1'b0;
      in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready && !flush;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) check("issue_timeout", 64'd0, 64'd1);
   endtask

   // counts edges after the accept edge until out_valid is seen
   task automatic wait_valid(output int n, output int rdy_hi);
      n = 0;
      rdy_hi = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) return;
         if (in_ready) rdy_hi++;
         n++;
      end
   endtask

   logic [31:0] tbl [8];

   initial begin
      int n, rh;
      bit seen;
      logic [6:0] one;
      int r;
      tbl[0] = 32'h3F800000; tbl[1] = 32'h40000000; tbl[2] = 32'h40400000; tbl[3] = 32'h3F000000;
      tbl[4] = 32'hBFC00000; tbl[5] = 32'h40C00000; tbl[6] = 32'h7F000000; tbl[7] = 32'hC0A00000;
      one = 7'd1;

      // reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_tag", 64'(out_tag), 64'd0);
      check("rst_src1", 64'(fpu_src1), 64'd0);
      check("rst_illegal", 64'(out_illegal), 64'd0);
      @(posedge clk); #1;

      // 1: FADD 1+2
      issue(7'b0000001, 32'h3F800000, 32'h40000000, 5'd3);
      wait_valid(n, rh);
      check("t1_lat", 64'(n), 64'd2);
      check("t1_data", 64'(out_data), 64'h40400000);
      check("t1_ovf", 64'(out_ovf), 64'd0);
      check("t1_tag", 64'(out_tag), 64'd3);
      @(posedge clk); #1;

      // 2: FDIV 6/2
      issue(7'b0001000, 32'h40C00000, 32'h40000000, 5'd4);
      wait_valid(n, rh);
      check("t2_lat", 64'(n), 64'd8);
      check("t2_ready_in_exec", 64'(rh), 64'd0);
      check("t2_data", 64'(out_data), 64'h40400000);
      @(posedge clk); #1;

      // 3: backpressure on FMUL 2*3
      out_ready = 1'b0;
      issue(7'b0000100, 32'h40000000, 32'h40400000, 5'd5);
      wait_valid(n, rh);
      check("t3_lat", 64'(n), 64'd3);
      @(posedge clk); #1;
      in_op = 7'b0000001; in_src1 = 32'h3F800000; in_src2 = 32'h3F800000; in_tag = 5'd7;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t3_hold_ready", 64'(in_ready), 64'd0);
         check("t3_hold_valid", 64'(out_valid), 64'd1);
         check("t3_hold_data", 64'(out_data), 64'h40C00000);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("t3_ready_rise", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_b2b_exec", 64'(out_valid), 64'd0);
      wait_valid(n, rh);
      check("t3_b2b_lat", 64'(n), 64'd1);
      check("t3_b2b_data", 64'(out_data), 64'h40000000);
      check("t3_b2b_tag", 64'(out_tag), 64'd7);
      @(posedge clk); #1;

      // 4: flush in third EXEC cycle of FDIV, then FLT 1<2
      issue(7'b0001000, 32'h40C00000, 32'h40000000, 5'd8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("t4_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("t4_no_valid", 64'(seen), 64'd0);
      @(posedge clk); #1;
      issue(7'b0100000, 32'h3F800000, 32'h40000000, 5'd9);
      wait_valid(n, rh);
      check("t4_flt_lat", 64'(n), 64'd1);
      check("t4_flt_data", 64'(out_data), 64'h00000001);
      @(posedge clk); #1;

      // 5: reset mid-EXEC of FMUL
      issue(7'b0000100, 32'h40400000, 32'h40400000, 5'd10);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t5_valid", 64'(out_valid), 64'd0);
      check("t5_fpu_op", 64'(fpu_op), 64'd0);
      check("t5_ready", 64'(in_ready), 64'd1);
      check("t5_data", 64'(out_data), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("t5_no_stale", 64'(seen), 64'd0);
      @(posedge clk); #1;

      // 6: multi-hot op
      issue(7'b0000011, 32'h3F800000, 32'h40000000, 5'd11);
      @(negedge clk);
      check("t6_fpu_op", 64'(fpu_op), 64'd0);
      wait_valid(n, rh);
      check("t6_lat", 64'(n), 64'd0);
      check("t6_illegal", 64'(out_illegal), 64'd1);
      check("t6_data", 64'(out_data), 64'd0);
      check("t6_ovf", 64'(out_ovf), 64'd0);
      check("t6_tag", 64'(out_tag), 64'd11);
      @(posedge clk); #1;

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         r = int'($urandom_range(0, 15));
         in_op     = (r < 14) ? (one << (r % 7)) : 7'($urandom);
         in_src1   = tbl[$urandom_range(0, 7)];
         in_src2   = tbl[$urandom_range(0, 7)];
         in_tag    = 5'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
